hwclk_tick_counter: RTL and testbench

//   Free-running hardware time base. It divides the core clock down to a tick

---
 rtl/hwclk_pkg.sv | 21 ++
 rtl/hwclk_prescaler.sv | 41 ++++
 rtl/hwclk_tick_counter.sv | 133 +++++++++++++
 tb/tb_hwclk_tick_counter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/hwclk_pkg.sv
// -----------------------------------------------------------------------------
// hwclk_pkg
//   Shared constants for the hardware clock tick counter: the register map of
//   the software write port and the bit layout of the CTRL register.
// -----------------------------------------------------------------------------
package hwclk_pkg;

    typedef logic [1:0] hwclk_addr_t;

    // Write-port register map (address 3 is reserved and ignored).
    localparam hwclk_addr_t ADDR_CTRL    = 2'd0;
    localparam hwclk_addr_t ADDR_LOAD    = 2'd1;
    localparam hwclk_addr_t ADDR_COMPARE = 2'd2;

    // CTRL bit indices: enable is a stored level, the rest are one-shot pulses.
    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_CLR_BIT     = 1;
    localparam int CTRL_CLR_OVF_BIT = 2;
    localparam int CTRL_CLR_IRQ_BIT = 3;

endpackage : hwclk_pkg

// File: rtl/hwclk_prescaler.sv
// -----------------------------------------------------------------------------
// hwclk_prescaler
//   Divides the core clock by DIV. Counts 0..DIV-1 while enabled and holds
//   otherwise.
// Ports:
//   clk        core clock
//   rst        synchronous, active-high reset
//   en         count enable (holds the count when low)
//   sync_clr   synchronous clear back to 0; overrides counting
//   wrap_pulse combinational: count is at DIV-1 and en=1 (wraps on this edge)
// -----------------------------------------------------------------------------
module hwclk_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sync_clr,
    output logic wrap_pulse
);
    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] count;

    assign wrap_pulse = en && (count == CW'(DIV - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (sync_clr) begin
            count <= '0;
        end else if (wrap_pulse) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

endmodule : hwclk_prescaler

// File: rtl/hwclk_tick_counter.sv
// -----------------------------------------------------------------------------
// hwclk_tick_counter
//   Free-running time base: the core clock is prescaled to TICK_HZ and each
//   prescaler wrap increments a WIDTH-bit counter that feeds the clock MMIO
//   stage. Software can enable, clear and load it; a sticky overflow flag
//   records wrap-around.
//   Optional feature (macro HWCLK_CMP_IRQ_EN): COMPARE register and a sticky
//   compare-match irq. Without the macro irq is tied low, COMPARE writes and
//   CTRL bit3 are ignored.
// Ports:
//   clk          core clock
//   rst          synchronous, active-high reset
//   wr_en        single-cycle register write strobe
//   wr_addr      0=CTRL 1=LOAD 2=COMPARE 3=reserved
//   wr_data      write data
//   new_counter  registered tick count
//   tick         one-cycle pulse following each increment
//   overflow     sticky wrap-from-all-ones flag
//   irq          sticky compare-match interrupt
// -----------------------------------------------------------------------------
module hwclk_tick_counter
    import hwclk_pkg::*;
#(
    parameter int CLK_HZ  = 10_000_000,
    parameter int TICK_HZ = 1_000,
    parameter int WIDTH   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [1:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] new_counter,
    output logic             tick,
    output logic             overflow,
    output logic             irq
);
    localparam int DIV = CLK_HZ / TICK_HZ;

    logic             enable;
    logic             wrap_pulse;
    logic             ctrl_wr;
    logic             load_wr;
    logic             clr_cnt;
    logic             clr_ovf;
    logic             inc;
    logic [WIDTH-1:0] counter_inc;

    // NOTE: every always_comb output is assigned unconditionally first, so no
    // path through the block can leave a value unassigned and infer a latch.
    always_comb begin
        ctrl_wr     = wr_en && (hwclk_addr_t'(wr_addr) == ADDR_CTRL);
        load_wr     = wr_en && (hwclk_addr_t'(wr_addr) == ADDR_LOAD);
        clr_cnt     = ctrl_wr && wr_data[CTRL_CLR_BIT];
        clr_ovf     = ctrl_wr && wr_data[CTRL_CLR_OVF_BIT];
        // Clear and load both outrank the prescaler increment; a suppressed
        // increment must not pulse tick or touch the sticky flags.
        inc         = wrap_pulse && !clr_cnt && !load_wr;
        counter_inc = new_counter + WIDTH'(1);
    end

    // Enable is the stored level, so a CTRL write changes counting only from
    // the following edge.
    hwclk_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk        (clk),
        .rst        (rst),
        .en         (enable),
        .sync_clr   (clr_cnt || load_wr),
        .wrap_pulse (wrap_pulse)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            enable      <= 1'b0;
            new_counter <= '0;
            tick        <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                enable <= wr_data[CTRL_EN_BIT];
            end

            if (clr_cnt) begin
                new_counter <= '0;
            end else if (load_wr) begin
                new_counter <= wr_data;
            end else if (inc) begin
                new_counter <= counter_inc;
            end

            tick <= inc;

            // A wrap on the same edge as a clear request wins.
            if (inc && (new_counter == '1)) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef HWCLK_CMP_IRQ_EN
    logic [WIDTH-1:0] compare;
    logic             cmp_wr;
    logic             clr_irq;

    assign cmp_wr  = wr_en && (hwclk_addr_t'(wr_addr) == ADDR_COMPARE);
    assign clr_irq = ctrl_wr && wr_data[CTRL_CLR_IRQ_BIT];

    // The match uses the pre-edge compare value, so a COMPARE write only
    // affects increments on later edges. Only real increments can match.
    always_ff @(posedge clk) begin
        if (rst) begin
            compare <= '1;
            irq     <= 1'b0;
        end else begin
            if (cmp_wr) begin
                compare <= wr_data;
            end
            if (inc && (counter_inc == compare)) begin
                irq <= 1'b1;
            end else if (clr_irq) begin
                irq <= 1'b0;
            end
        end
    end
`else
    assign irq = 1'b0;
`endif

endmodule : hwclk_tick_counter

// File: tb/tb_hwclk_tick_counter.sv
// -----------------------------------------------------------------------------
// tb_hwclk_tick_counter
//   Directed bench for hwclk_tick_counter with CLK_HZ=8, TICK_HZ=2 (DIV=4).
//   The stimulus process pushes hand-computed expectations for the state after
//   the edge just driven; the monitor pops and compares them at the following
//   falling edge. Define HWCLK_CMP_IRQ_EN to exercise the compare interrupt.
// -----------------------------------------------------------------------------
module tb_hwclk_tick_counter;
    import hwclk_pkg::*;

    localparam int WIDTH = 32;

`ifdef HWCLK_CMP_IRQ_EN
    localparam logic CMP_EN = 1'b1;
`else
    localparam logic CMP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {F_CNT, F_TICK, F_OVF, F_IRQ} field_e;

    typedef struct {
        field_e      f;
        logic [31:0] v;
        string       name;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             wr_en;
    logic [1:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] new_counter;
    logic             tick;
    logic             overflow;
    logic             irq;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_total;
    int   n_pass;

    hwclk_tick_counter #(
        .CLK_HZ  (8),
        .TICK_HZ (2),
        .WIDTH   (WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .new_counter (new_counter),
        .tick        (tick),
        .overflow    (overflow),
        .irq         (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: compares every pending expectation against the settled outputs.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            case (mon_e.f)
                F_CNT:   check(mon_e.name, new_counter, mon_e.v);
                F_TICK:  check(mon_e.name, {31'd0, tick}, mon_e.v);
                F_OVF:   check(mon_e.name, {31'd0, overflow}, mon_e.v);
                default: check(mon_e.name, {31'd0, irq}, mon_e.v);
            endcase
        end
    end

    task automatic expect_val(input field_e f, input logic [31:0] v, input string name);
        exp_t e;
        e.f    = f;
        e.v    = v;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Advance n rising edges; return just after the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-edge register write.
    task automatic wr(input hwclk_addr_t a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step(1);
        wr_en   = 1'b0;
        wr_addr = 2'd0;
        wr_data = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = 2'd0;
        wr_data = '0;

        // Reset state
        step(2);
        expect_val(F_CNT,  32'd0, "reset_cnt");
        expect_val(F_TICK, 32'd0, "reset_tick");
        expect_val(F_OVF,  32'd0, "reset_ovf");
        expect_val(F_IRQ,  32'd0, "reset_irq");
        rst = 1'b0;
        step(1);

        // Enable: first increment exactly 4 edges later
        wr(ADDR_CTRL, 32'h1);
        step(1); expect_val(F_CNT, 32'd0, "en_edge1");
        step(1); expect_val(F_CNT, 32'd0, "en_edge2");
        step(1); expect_val(F_CNT, 32'd0, "en_edge3");
                 expect_val(F_TICK, 32'd0, "en_edge3_tick");
        step(1); expect_val(F_CNT, 32'd1, "en_edge4");
                 expect_val(F_TICK, 32'd1, "en_edge4_tick");
        step(1); expect_val(F_TICK, 32'd0, "en_edge5_tick");
        step(15); expect_val(F_CNT, 32'd5, "en_edge20");

        // Wrap-around and sticky overflow
        wr(ADDR_LOAD, 32'hFFFF_FFFE);
        expect_val(F_CNT, 32'hFFFF_FFFE, "load_fffe");
        step(4); expect_val(F_CNT, 32'hFFFF_FFFF, "run_ffff");
                 expect_val(F_OVF, 32'd0, "ovf_before_wrap");
        step(4); expect_val(F_CNT, 32'd0, "wrap_to_0");
                 expect_val(F_OVF, 32'd1, "ovf_set");
        step(3); expect_val(F_OVF, 32'd1, "ovf_sticky");
        // This write lands on a prescaler wrap: counter 0->1, overflow cleared.
        wr(ADDR_CTRL, 32'h5);
        expect_val(F_OVF, 32'd0, "ovf_cleared");
        expect_val(F_CNT, 32'd1, "run_after_clr_ovf");
        step(4); expect_val(F_CNT, 32'd2, "keeps_running");

        // CTRL.clear on a prescaler-wrap edge suppresses the increment
        step(3);
        wr(ADDR_CTRL, 32'h3);
        expect_val(F_CNT,  32'd0, "clear_on_wrap_cnt");
        expect_val(F_TICK, 32'd0, "clear_on_wrap_tick");
        step(3); expect_val(F_CNT, 32'd0, "clear_presc_zero");
        step(1); expect_val(F_CNT, 32'd1, "clear_then_inc");
        // LOAD on a prescaler-wrap edge suppresses the increment
        step(3);
        wr(ADDR_LOAD, 32'h55);
        expect_val(F_CNT,  32'h55, "load_on_wrap_cnt");
        expect_val(F_TICK, 32'd0,  "load_on_wrap_tick");
        step(4); expect_val(F_CNT, 32'h56, "load_then_inc");

        // Disable with prescaler at 2, freeze, re-enable
        step(1);
        wr(ADDR_CTRL, 32'h0);
        step(10); expect_val(F_CNT,  32'h56, "frozen_cnt");
                  expect_val(F_TICK, 32'd0,  "frozen_tick");
        wr(ADDR_CTRL, 32'h1);
        step(1); expect_val(F_CNT, 32'h56, "reen_edge1");
        step(1); expect_val(F_CNT, 32'h57, "reen_edge2");
                 expect_val(F_TICK, 32'd1, "reen_tick");

        // Reserved address write is ignored
        wr(2'd3, 32'h2);
        step(3); expect_val(F_CNT, 32'h58, "reserved_ignored");

        // Compare interrupt (irq stays 0 when the feature is absent)
        wr(ADDR_CTRL, 32'h2);
        expect_val(F_CNT, 32'd0, "cmp_setup_clear");
        wr(ADDR_COMPARE, 32'd3);
        wr(ADDR_CTRL, 32'h1);
        step(11); expect_val(F_CNT, 32'd2, "cmp_cnt2");
                  expect_val(F_IRQ, 32'd0, "irq_before_match");
        wr(ADDR_CTRL, 32'h9);
        expect_val(F_CNT, 32'd3, "cmp_cnt3");
        expect_val(F_IRQ, {31'd0, CMP_EN}, "irq_set_beats_clr");
        step(2); expect_val(F_IRQ, {31'd0, CMP_EN}, "irq_sticky");
        wr(ADDR_CTRL, 32'h9);
        expect_val(F_IRQ, 32'd0, "irq_cleared");

        // Build up counter=0x1234, overflow=1, irq=1 and reset
        wr(ADDR_LOAD, 32'hFFFF_FFFF);
        step(4); expect_val(F_OVF, 32'd1, "pre_rst_ovf");
        wr(ADDR_LOAD, 32'd2);
        step(4); expect_val(F_IRQ, {31'd0, CMP_EN}, "pre_rst_irq");
        wr(ADDR_LOAD, 32'h1234);
        expect_val(F_CNT, 32'h1234, "pre_rst_cnt");
        rst = 1'b1;
        step(1);
        expect_val(F_CNT,  32'd0, "rst_cnt");
        expect_val(F_TICK, 32'd0, "rst_tick");
        expect_val(F_OVF,  32'd0, "rst_ovf");
        expect_val(F_IRQ,  32'd0, "rst_irq");
        rst = 1'b0;
        step(8); expect_val(F_CNT, 32'd0, "rst_disabled");

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_hwclk_tick_counter
